if_id_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register for the five-stage MIPS pipeline. It owns the PC, drives the instruction-memory address, and registers the fetched word with its PC+4. It presents decoded fields (`Opcode`, `func`, `Rt`, …) to the control unit. It consumes the control unit's `PCSrc` decision, and the forwarded `rs` value, to redirect fetch for branches, jumps and register jumps.

---
 rtl/pip_pkg.sv | 38 +++
 rtl/if_id_stage_if.sv | 21 ++
 rtl/if_id_stage_npc_calc.sv | 20 ++
 rtl/if_id_stage.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared definitions for the IF/ID stage: PCSrc encodings, instruction field
// positions, default reset PC, fetch FSM states and the branch-offset helper.
package pip_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPC_MSB  = 31;
    localparam int unsigned OPC_LSB  = 26;
    localparam int unsigned RS_MSB   = 25;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_MSB   = 20;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_MSB   = 15;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned FUNC_MSB = 5;
    localparam int unsigned FUNC_LSB = 0;
    localparam int unsigned IMM_MSB  = 15;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned JIDX_MSB = 25;
    localparam int unsigned JIDX_LSB = 0;

    function automatic logic [31:0] sext_shl2(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and imem (slave).
interface if_id_stage_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/if_id_stage_npc_calc.sv
// Combinational redirect-target generation for the instruction held in ID.
module npc_calc
    import pip_pkg::*;
(
    input  logic [31:0] i_pc4,
    input  logic [25:0] i_jidx,
    input  logic [31:0] i_rs_data,
    output logic [31:0] o_br_target,
    output logic [31:0] o_j_target,
    output logic [31:0] o_jr_target,
    output logic        o_misalign
);
    logic [15:0] w_imm;

    assign w_imm       = i_jidx[IMM_MSB:IMM_LSB];
    assign o_br_target = i_pc4 + sext_shl2(w_imm);
    assign o_j_target  = {i_pc4[31:28], i_jidx, 2'b00};
    assign o_jr_target = {i_rs_data[31:2], 2'b00};
    assign o_misalign  = |i_rs_data[1:0];
endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch + IF/ID pipeline register for the 5-stage MIPS pipeline.
// Optional feature: define BRANCH_DELAY_SLOT_EN for delay-slot semantics.
module if_id_stage
    import pip_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic [1:0]    PCSrc,
    input  logic [31:0]   rs_data,
    if_id_stage_if.master imem,
    output logic          id_valid,
    output logic [31:0]   id_instr,
    output logic [31:0]   id_pc4,
    output logic [31:0]   id_link,
    output logic [5:0]    Opcode,
    output logic [5:0]    func,
    output logic [4:0]    Rs,
    output logic [4:0]    Rt,
    output logic [4:0]    Rd,
    output logic [15:0]   id_imm,
    output logic          pc_misalign
);
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_misalign;

    logic [31:0] w_pc4;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_jr_target;
    logic        w_npc_misalign;
    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_redirect_misalign;
    pc_src_e     w_src;

`ifdef BRANCH_DELAY_SLOT_EN
    fetch_state_e r_state;
    logic [31:0]  r_target;
`endif

    npc_calc u_npc_calc (
        .i_pc4       (r_id_pc4),
        .i_jidx      (r_id_instr[JIDX_MSB:JIDX_LSB]),
        .i_rs_data   (rs_data),
        .o_br_target (w_br_target),
        .o_j_target  (w_j_target),
        .o_jr_target (w_jr_target),
        .o_misalign  (w_npc_misalign)
    );

    assign w_src               = pc_src_e'(PCSrc);
    assign w_pc4               = r_pc + 32'd4;
    assign w_redirect          = r_id_valid && (w_src != PC_SEQ);
    assign w_redirect_misalign = w_redirect && (w_src == PC_JR) && w_npc_misalign;

    always_comb begin
        w_target = w_pc4;
        case (w_src)
            PC_BR:   w_target = w_br_target;
            PC_J:    w_target = w_j_target;
            PC_JR:   w_target = w_jr_target;
            default: w_target = w_pc4;
        endcase
    end

    // Bubble keeps id_pc4 unchanged; only valid/instr are forced to a nop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc4   <= '0;
            r_misalign <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
            r_state    <= RUN;
            r_target   <= '0;
`endif
        end else if (stall) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect_misalign;
`ifdef BRANCH_DELAY_SLOT_EN
            if (r_state == PEND) begin
                if (imem.imem_ready) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= imem.imem_rdata;
                    r_id_pc4   <= w_pc4;
                    r_pc       <= r_target;
                    r_state    <= RUN;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_instr <= '0;
                end
            end else if (w_redirect) begin
                if (imem.imem_ready) begin
                    r_id_valid <= 1'b1;
                    r_id_instr <= imem.imem_rdata;
                    r_id_pc4   <= w_pc4;
                    r_pc       <= w_target;
                end else begin
                    r_id_valid <= 1'b0;
                    r_id_instr <= '0;
                    r_target   <= w_target;
                    r_state    <= PEND;
                end
            end else if (imem.imem_ready) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem.imem_rdata;
                r_id_pc4   <= w_pc4;
                r_pc       <= w_pc4;
            end else begin
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
            end
`else
            if (w_redirect) begin
                r_pc       <= w_target;
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
            end else if (imem.imem_ready) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem.imem_rdata;
                r_id_pc4   <= w_pc4;
                r_pc       <= w_pc4;
            end else begin
                r_id_valid <= 1'b0;
                r_id_instr <= '0;
            end
`endif
        end
    end

    assign imem.imem_addr = r_pc;
    assign imem.imem_req  = !rst;

    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc4      = r_id_pc4;
    assign pc_misalign = r_misalign;
`ifdef BRANCH_DELAY_SLOT_EN
    assign id_link     = r_id_pc4 + 32'd4;
`else
    assign id_link     = r_id_pc4;
`endif

    assign Opcode = r_id_instr[OPC_MSB:OPC_LSB];
    assign func   = r_id_instr[FUNC_MSB:FUNC_LSB];
    assign Rs     = r_id_instr[RS_MSB:RS_LSB];
    assign Rt     = r_id_instr[RT_MSB:RT_LSB];
    assign Rd     = r_id_instr[RD_MSB:RD_LSB];
    assign id_imm = r_id_instr[IMM_MSB:IMM_LSB];
endmodule
